// File: rtl/imem_byte_writer.sv
// Run-time program loader: accepts 32-bit words over valid/ready and writes them
// MSB first as four byte writes into the byte-addressed, big-endian instruction memory.
//
// state  | meaning
// IDLE   | waiting for start; start with a misaligned base goes straight to ERROR
// ACCEPT | word_ready high, waiting for a word handshake
// WRITE  | one byte write per cycle, byte_idx 0..3, MSB to the lowest address
// DONE   | one-cycle done pulse after the word flagged last
// ERROR  | misaligned base or word past the end of memory; err stays set
module imem_byte_writer #(
    parameter int MEM_BYTES = 73,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        byte_idx;
    logic [23:0]       word_rest;
    logic              last_q;
    logic [ADDR_W:0]   word_end;
    logic              word_oob;

    // One extra bit so a base near the top of the address space cannot wrap past the check.
    assign word_end = {1'b0, cur_addr} + (ADDR_W+1)'(3);
    assign word_oob = (word_end > LAST_BYTE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            byte_idx   <= '0;
            word_rest  <= '0;
            last_q     <= 1'b0;
            word_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (base_addr[1:0] != 2'b00) begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end else begin
                            cur_addr   <= base_addr;
                            err        <= 1'b0;
                            word_ready <= 1'b1;
                            state      <= ACCEPT;
                        end
                    end
                end
                ACCEPT: begin
                    if (word_valid && word_ready) begin
                        word_ready <= 1'b0;
                        if (word_oob) begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end else begin
                            // First byte goes out the cycle after the handshake.
                            byte_idx  <= 2'd0;
                            mem_we    <= 1'b1;
                            mem_addr  <= cur_addr;
                            mem_wdata <= word_data[31:24];
                            word_rest <= word_data[23:0];
                            last_q    <= word_last;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (byte_idx == 2'd3) begin
                        mem_we   <= 1'b0;
                        byte_idx <= 2'd0;
                        cur_addr <= cur_addr + ADDR_W'(4);
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            word_ready <= 1'b1;
                            state      <= ACCEPT;
                        end
                    end else begin
                        byte_idx  <= byte_idx + 2'd1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= word_rest[23:16];
                        word_rest <= {word_rest[15:0], 8'h00};
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERROR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    word_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_byte_writer.md
Name: imem_byte_writer

Overview:
- Write-side counterpart of the byte-addressed, big-endian instruction memory: loads a program into instruction memory at run time instead of only from the init file.
- Accepts 32-bit instruction words over a valid/ready stream, starting at a word-aligned base address.
- Issues four byte writes per word, MSB first, to the memory's 8-bit write port, auto-incrementing the address.
- Sits between the boot/debug loader and the instruction memory; asserts done after the word flagged last.

Parameters:
- MEM_BYTES, 73, number of bytes in the instruction memory; valid byte addresses are 0..MEM_BYTES-1.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load at base_addr; honoured only in IDLE.
- base_addr  in  ADDR_W  first byte address of the load; must have bits [1:0] = 0.
- word_valid  in  1  word_data/word_last are valid.
- word_data  in  32  instruction word; bits [31:24] go to the lowest address.
- word_last  in  1  marks the final word of the load.
- word_ready  out  1  block can accept a word this cycle.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte address for the write.
- mem_wdata  out  8  byte to write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final byte write.
- err  out  1  sticky error flag; cleared only by reset or by an accepted start.

Behaviour:
- Moore machine: every output is a function of registered state only.
- Reset (async, any time, including mid-word): state=IDLE, cur_addr=0, byte_idx=0, word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. A word interrupted by reset is abandoned; bytes already written stay in memory.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE, start=1:
  - if base_addr[1:0]!=0 -> ERROR, err=1;
  - else cur_addr<=base_addr, err<=0, -> ACCEPT.
  - start while not in IDLE is ignored.
- ACCEPT: word_ready=1. On word_valid&word_ready, latch word_data and word_last.
  - If cur_addr+3 > MEM_BYTES-1 (compute in ADDR_W+1 bits; no wrap): -> ERROR, no write.
  - Else -> WRITE with byte_idx=0.
  - word_valid=0: stay in ACCEPT indefinitely.
- WRITE: mem_we=1, mem_addr=cur_addr+byte_idx, mem_wdata=word[31-8*byte_idx -: 8].
  - byte_idx 0,1,2: increment byte_idx.
  - byte_idx 3: cur_addr<=cur_addr+4, byte_idx<=0; -> DONE if latched last, else -> ACCEPT.
  - word_ready=0 throughout WRITE.
- Timing:
  - One word costs exactly 5 cycles minimum: 1 handshake cycle + 4 write cycles.
  - First write occurs the cycle after the handshake.
- DONE: done=1 for exactly one cycle -> IDLE.
- ERROR: err=1, busy=1, word_ready=0, mem_we=0; -> IDLE on the next cycle. err stays 1 until reset or the next accepted start.
- mem_addr and mem_wdata hold their last values when mem_we=0; the memory ignores them.
- Simultaneous start and word_valid in IDLE: start is taken; the word is not accepted (word_ready=0 in IDLE).
- A load ending exactly at byte MEM_BYTES-1 is legal.

Test Plan:
- Single-word load: reset, start with base_addr=0, word 0x8C010004 with last=1 -> bytes 0x8C,0x01,0x00,0x04 written to addrs 0..3 on 4 consecutive cycles; done pulses 1 cycle later; mem[0..3] reads back 0x8C010004.
- Three-word load with word_valid gaps: base_addr=8 -> 12 byte writes to addrs 8..19 in order; word_ready high only in ACCEPT; done exactly once.
- Bounds: base_addr=68 (MEM_BYTES=73), two words -> first word written to 68..71; second handshake -> ERROR, no write to 72..75, err=1, done never asserted.
- Misaligned start: base_addr=0x6 -> err=1 the next cycle, no mem_we. A following start with base_addr=0 clears err and loads normally.
- Reset mid-word: assert reset during byte_idx=2 -> all outputs 0 immediately (async, before the next clock edge); only 2 bytes written; a subsequent load works normally.
- Ignored start: pulse start during WRITE with a different base_addr -> no effect; writes continue at the original addresses.
